// File: rtl/edge_event_sched.sv
// Per-channel rise/fall edge detector feeding a round-robin valid/ready event port; level-to-valid is 2 cycles, events stay stable under backpressure.
// Optional EDGE_EVT_TIMESTAMP_EN adds a free-running timestamp captured when an event becomes pending.
module edge_event_sched #(
    parameter int NUM_CH = 4,
    parameter int SEQ_W  = 8,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          sig_in,
    input  logic [2*NUM_CH-1:0]        cfg_mask,
    input  logic                       ovf_clr,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_CH)-1:0]  evt_ch,
    output logic [1:0]                 evt_kind,
    output logic [SEQ_W-1:0]           evt_seq,
`ifdef EDGE_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]            evt_ts,
`endif
    output logic [NUM_CH-1:0]          ovf
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t             state, state_nxt;
    logic [NUM_CH-1:0]  prev, pend, en_edge, grant, ovf_set;
    logic [1:0]         pkind     [NUM_CH];
    logic [1:0]         edge_kind [NUM_CH];
    logic [CH_W-1:0]    last_grant, winner, cand;
    logic               any_pend, arb_found, handshake, load;
    logic [SEQ_W-1:0]   seq_cnt, seq_nxt;
    int                 arb_idx;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            edge_kind[i] = prev[i] ? 2'd2 : 2'd1;
            en_edge[i]   = (sig_in[i] ^ prev[i]) & (prev[i] ? cfg_mask[2*i+1] : cfg_mask[2*i]);
        end
    end

    // Round-robin: the first pending channel after the last one granted wins.
    always_comb begin
        winner    = '0;
        cand      = '0;
        arb_found = 1'b0;
        arb_idx   = 0;
        any_pend  = |pend;
        for (int k = 1; k <= NUM_CH; k++) begin
            arb_idx = int'(last_grant) + k;
            if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
            cand = CH_W'(arb_idx);
            if (!arb_found && pend[cand]) begin
                arb_found = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        handshake = (state == PRESENT) && evt_ready;
        load      = any_pend && ((state == IDLE) || handshake);
        seq_nxt   = handshake ? seq_cnt + SEQ_W'(1) : seq_cnt;
        grant     = load ? (NUM_CH'(1) << winner) : '0;
        ovf_set   = en_edge & pend & ~grant;
        case (state)
            IDLE:    if (any_pend) state_nxt = PRESENT;
            PRESENT: if (handshake && !any_pend) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign evt_valid = (state == PRESENT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            pend       <= '0;
            ovf        <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            seq_cnt    <= '0;
            evt_ch     <= '0;
            evt_kind   <= '0;
            evt_seq    <= '0;
            for (int i = 0; i < NUM_CH; i++) pkind[i] <= '0;
        end else begin
            prev    <= sig_in;
            seq_cnt <= seq_nxt;
            ovf     <= (ovf & {NUM_CH{~ovf_clr}}) | ovf_set;
            // A slot that is empty or being granted takes the new edge; a busy one keeps the oldest kind.
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant[i] || !pend[i]) begin
                    pend[i] <= en_edge[i];
                    if (en_edge[i]) pkind[i] <= edge_kind[i];
                end
            end
            if (load) begin
                evt_ch     <= winner;
                evt_kind   <= pkind[winner];
                evt_seq    <= seq_nxt;
                last_grant <= winner;
            end
        end
    end

`ifdef EDGE_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            evt_ts <= '0;
            for (int i = 0; i < NUM_CH; i++) ts[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (en_edge[i] && (!pend[i] || grant[i])) ts[i] <= ts_cnt;
            end
            if (load) evt_ts <= ts[winner];
        end
    end
`endif

endmodule

// File: doc/edge_event_sched.md
# edge_event_sched

Multi-channel edge-event scheduler for the register map. It watches NUM_CH level inputs (status bits, trigger lines) and detects rising and falling edges per channel under a per-channel enable mask. Detected events are queued as one pending slot per channel and issued one at a time over a valid/ready port, using round-robin arbitration. It sits between raw status levels and the register-map event/interrupt FIFO, so bursts of simultaneous edges are serialized without loss except where overflow is flagged.

## Interface
- NUM_CH, 4, number of monitored channels (2..16)
- SEQ_W, 8, width of issued-event sequence number
- TS_W, 16, timestamp width (used only with EDGE_EVT_TIMESTAMP_EN)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sig_in  in  NUM_CH  monitored levels, already synchronous to clk
- cfg_mask  in  2*NUM_CH  per channel i: bit 2i = rise enable, bit 2i+1 = fall enable
- ovf_clr  in  1  single-cycle pulse, clears all overflow flags
- evt_valid  out  1  event presented
- evt_ready  in  1  consumer accepts event
- evt_ch  out  $clog2(NUM_CH)  channel index of the event
- evt_kind  out  2  1 = rising, 2 = falling (0 never presented)
- evt_seq  out  SEQ_W  sequence number of the event
- ovf  out  NUM_CH  sticky per-channel overflow flags
- evt_ts  out  TS_W  event timestamp (present only with the macro)

## Operation
- Edge detect per channel: prev[i] register, reset 0, loaded with sig_in[i] every cycle. An edge is sig_in[i] != prev[i]. Its kind is 1 if prev=0, else 2.
- An edge is enabled only if its cfg_mask bit is 1. Disabled edges are ignored but still update prev.
- Pending slot per channel: pend[i], pkind[i].
  - An enabled edge with pend[i]=0 sets pend[i] and stores the kind.
  - An enabled edge with pend[i]=1 that is not cleared this cycle keeps the oldest kind and sets ovf[i].
- Grant clears pend[i] on the same edge as the output load. An enabled edge arriving in that cycle re-sets pend[i] with the new kind and does not set ovf.
- ovf[i] is sticky until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, ovf[i] ends at 1.
- Arbiter: round-robin over pend. Search starts at last_grant+1 mod NUM_CH. last_grant resets to NUM_CH-1, so channel 0 has first priority after reset.
- FSM:
  - IDLE (evt_valid=0): if any pend is set, load evt_ch/evt_kind/evt_seq (plus evt_ts with the macro) from the winner, clear its pend, update last_grant, then go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (evt_valid=1): all evt_* outputs stay stable while evt_ready=0.
    - On evt_valid & evt_ready, seq increments, wrapping at 2^SEQ_W.
    - If any pend is set (pend as registered, excluding edges arriving this cycle), load the next winner in the same cycle and stay in PRESENT.
    - Otherwise go to IDLE.
- evt_seq is the value of seq_cnt at load time. The first event after reset has seq 0.
- Changing cfg_mask affects only edges in the same cycle and later. Already-pending events are kept.

## Timing
- Reset values: evt_valid 0, evt_ch 0, evt_kind 0, evt_seq 0, ovf 0, evt_ts 0, all prev/pend 0, seq_cnt 0. Reset acts immediately, asynchronously, including mid-handshake. Any presented or pending event is discarded.
- Latency:
  - sig_in changes before clock edge k; pend is set at edge k.
  - With the FSM in IDLE, evt_valid rises after edge k+1, giving 2 cycles from level change to valid.
- Throughput: one event per cycle while evt_ready=1 and pend is non-empty.
- A sig_in level high at reset release produces a rising event (prev resets to 0).
- Sustained edges on one channel faster than it is granted set ovf. At most one event per channel is outstanding in pend, plus one in the output register.

## Configuration
- EDGE_EVT_TIMESTAMP_EN defined:
  - A free-running TS_W counter (reset 0, wraps) is captured into a per-channel ts register whenever pend[i] is newly set.
  - The captured value is presented on evt_ts with the event.
  - Overflowing edges do not update ts.
- Not defined: evt_ts port, the counter and the ts registers are absent. All other behaviour is identical.

## Test plan
- NUM_CH=4, cfg_mask=all 1, sig_in[2] 0->1 at edge 10, evt_ready=1 -> evt_valid=1 after edge 11 with ch 2, kind 1, seq 0, for exactly one cycle.
- All four channels rise in the same cycle, evt_ready=1 -> events for ch 0,1,2,3 on 4 consecutive cycles with seq 0..3. A second simultaneous burst is then served as 0,1,2,3.
- evt_ready=0 while ch1 toggles twice -> outputs held stable. Second toggle sets ovf[1]=1 and pend keeps kind 1. ovf_clr pulse -> ovf=0.
- cfg_mask rise-only on ch0, pulse sig_in[0] high for 3 cycles -> exactly one event, kind 1. No falling event is reported.
- rst asserted mid-PRESENT with 2 pending -> evt_valid=0 immediately. After release, no events issue until a new edge; seq restarts at 0.
- With EDGE_EVT_TIMESTAMP_EN: edge on ch3 at timestamp 0x0005, evt_ready held 0 for 10 cycles -> evt_ts=0x0005 at acceptance.
